// File: rtl/arb_round_robin.sv
// arb_round_robin: registered round-robin arbiter over two LSB-first priority-to-one-hot trees
module pry2oht_tree #(
  parameter int WIDTH = 32,
  parameter int SPLIT = 2
) (
  input  logic [WIDTH-1:0] dat,
  output logic [WIDTH-1:0] oht,
  output logic             vld
);
  if (WIDTH <= SPLIT) begin : g_leaf
    always_comb begin
      vld = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        oht[i] = dat[i] & ~vld;
        vld = vld | dat[i];
      end
    end
  end else begin : g_node
    localparam int SUB = (WIDTH + SPLIT - 1) / SPLIT;
    localparam int GRP = (WIDTH + SUB - 1) / SUB;
    logic [GRP-1:0] sub_vld, sel;
    always_comb begin
      sel = '0;
      for (int i = 0; i < GRP; i++)
        sel[i] = sub_vld[i] & ~|(sub_vld & ((GRP'(1) << i) - GRP'(1)));
    end
    for (genvar g = 0; g < GRP; g++) begin : g_grp
      localparam int LO = g * SUB;
      localparam int GW = (g == GRP - 1) ? WIDTH - LO : SUB;
      logic [GW-1:0] sub_oht;
      pry2oht_tree #(.WIDTH(GW), .SPLIT(SPLIT)) u_sub (
        .dat(dat[LO +: GW]),
        .oht(sub_oht),
        .vld(sub_vld[g])
      );
      assign oht[LO +: GW] = sel[g] ? sub_oht : '0;
    end
    assign vld = |sub_vld;
  end
endmodule

module arb_round_robin #(
  parameter  int WIDTH     = 32,
  parameter  int SPLIT     = 2,
  localparam int WIDTH_LOG = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     req,
  output logic [WIDTH-1:0]     gnt,
  output logic [WIDTH_LOG-1:0] gnt_idx,
  output logic                 gnt_vld,
  input  logic                 gnt_rdy
);
  logic [WIDTH_LOG-1:0] ptr, idx, nxt_ptr;
  logic [WIDTH-1:0] msk, a_oht, b_oht, win;
  logic a_vld, arb_vld, load;
  always_comb begin
    msk = '0;
    for (int i = 0; i < WIDTH; i++) msk[i] = i >= int'(ptr);
  end
  pry2oht_tree #(.WIDTH(WIDTH), .SPLIT(SPLIT)) u_a (.dat(req & msk), .oht(a_oht), .vld(a_vld));
  pry2oht_tree #(.WIDTH(WIDTH), .SPLIT(SPLIT)) u_b (.dat(req), .oht(b_oht), .vld(arb_vld));
  assign win = a_vld ? a_oht : b_oht;
  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) idx = idx | (win[i] ? WIDTH_LOG'(i) : '0);
  end
  assign nxt_ptr = (idx == WIDTH_LOG'(WIDTH - 1)) ? '0 : idx + 1'b1;
  assign load = ~gnt_vld | gnt_rdy;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt     <= '0;
      gnt_idx <= '0;
      gnt_vld <= 1'b0;
      ptr     <= '0;
    end else if (load) begin
      gnt     <= win;
      gnt_idx <= idx;
      gnt_vld <= arb_vld;
      if (arb_vld) ptr <= nxt_ptr;
    end
  end
endmodule

// File: doc/arb_round_robin.md
# arb_round_robin

Registered round-robin arbiter built around the priority-to-one-hot tree (`pry2oht_tree`). It takes a request vector, rotates priority with a pointer, and emits a one-hot grant plus binary index through a valid/ready output register. It sits directly upstream of the one-hot consumers: the grant is the stable, handshaked form of the converter's output.

## Interface
- `WIDTH`, 32: number of requesters; any value ≥ 2.
- `SPLIT`, 2: tree split factor, passed unchanged to both internal `pry2oht_tree` instances.
- `WIDTH_LOG`, localparam `$clog2(WIDTH)`: index width.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `req`  in  WIDTH  request vector; bit i means requester i wants service.
- `gnt`  out  WIDTH  registered one-hot grant.
- `gnt_idx`  out  WIDTH_LOG  registered binary index of the set bit in `gnt`.
- `gnt_vld`  out  1  grant valid.
- `gnt_rdy`  in  1  consumer accepts the grant.

## Operation
- State:
  - pointer `ptr` [WIDTH_LOG-1:0], the lowest-priority-boundary index.
  - output register `gnt`, `gnt_idx`, `gnt_vld`.
- Mask: `msk[i] = (i >= ptr)`.
- Arbitration, combinational, using two `pry2oht_tree` instances in LSB direction:
  - A is fed `req & msk`.
  - B is fed `req`.
  - If A is valid, the winner is A's one-hot; otherwise the winner is B's one-hot.
  - `arb_vld = |req`.
- Winner index: one-hot to binary encode of the winner; 0 when `arb_vld = 0`.
- `load = ~gnt_vld | gnt_rdy`.
- On `load`:
  - `gnt <= winner`, `gnt_idx <= idx`, `gnt_vld <= arb_vld`.
  - If `arb_vld`, then `ptr <= (idx == WIDTH-1) ? 0 : idx+1`, wrapping modulo WIDTH, including non-power-of-2 WIDTH.
  - If `~arb_vld`, `ptr` holds.
- Stall (`gnt_vld & ~gnt_rdy`): `gnt`, `gnt_idx`, `gnt_vld` and `ptr` all hold. The grant is sticky even if `req` deasserts or changes.
- Handshake and reload in the same cycle: the accepted grant retires and the next winner loads in the same edge. Full throughput is 1 grant/cycle.
- The currently granted requester may be granted again next only if it is the sole requester (pointer already advanced past it).
- Fairness: with all requesters continuously active and `gnt_rdy = 1`, every requester is granted exactly once per WIDTH consecutive grants.
- `gnt` is always zero or one-hot. `gnt = 0` iff `gnt_vld = 0`.

## Timing
- Reset values (asynchronous, immediate on `rst` = 1): `gnt = 0`, `gnt_idx = 0`, `gnt_vld = 0`, `ptr = 0`.
- First edge after `rst` deasserts performs a normal `load` (`gnt_vld` = 0, so `load` = 1).
- Latency: `req` sampled at edge n gives `gnt`/`gnt_vld` valid after edge n, i.e. 1 cycle.
- No combinational path from `req` or `gnt_rdy` to any output.
- `gnt_rdy` reaches state only through `load`. A consumer may hold `gnt_rdy` = 1 permanently.
- `gnt_vld` may drop only after a handshake cycle with `req` = 0 at that edge.
- Reset mid-stall: the pending grant is discarded and `ptr` returns to 0. No grant is replayed.
- X on `req` bits of lower priority than the winner must not corrupt `gnt`. Bits above the winner within the masked window are don't-care, as in the tree.

## Test plan
- Reset/idle:
  - Assert `rst` with `req` = 32'hFFFF_FFFF: outputs immediately 0; `ptr` = 0.
  - Release with `req` = 0: `gnt_vld` stays 0 for 10 cycles.
- Round robin:
  - `req` = 32'hFFFF_FFFF, `gnt_rdy` = 1 from cycle 0: `gnt_idx` sequence 0,1,…,31,0,1.
  - One grant per cycle, `gnt` = 1<<`gnt_idx` each cycle.
- Sparse and wrap:
  - `req` = 32'h8000_0011, `gnt_rdy` = 1: grants 0,4,31,0,4,31.
  - Then `req` = 32'h0000_0001 alone: grants 0 every cycle.
- Backpressure:
  - `req` = 32'h0000_0006, `gnt_rdy` = 0 for 5 cycles: `gnt` = 32'h2, `gnt_idx` = 1 held.
  - Drop `req` to 0 during the stall: grant still held.
  - Raise `gnt_rdy` for 1 cycle: next `gnt_vld` = 0.
- Simultaneous handshake/reload:
  - `req` = 32'h0000_0003 with `gnt_rdy` toggling 1,0,1,1: grants 0 (accepted), 1 (held one cycle, then accepted), 0.
  - `ptr` advances only on load.
- Mid-operation reset:
  - After grants 0..5 with `req` = all ones, pulse `rst` during a stall on idx 6: outputs 0 immediately.
  - After release, first grant `gnt_idx` = 0.
- All scenarios also run with `WIDTH` = 5, `SPLIT` = 3, including wrap 4→0.
